enc7_led: RTL and testbench

Registered hexadecimal/decimal seven-segment glyph encoder for one DE1-SoC HEX digit. It converts a 4-bit value into the segment drive pattern and sits between status or debug registers and the HEX display pins. Several instances are used side by side, one per digit, for example to display bus addresses and bit counters. The output is registered, so the display never shows decode glitches.

---
 rtl/enc7_led.sv | 59 +++++
 tb/tb_enc7_led.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/enc7_led.sv
// Registered 7-segment glyph encoder for one HEX digit (hex or decimal mode).
// Latency: 1 clk from vinp/enchx to leds; reset blanks the digit immediately.
// Backpressure: none, a new value is accepted every cycle.
module enc7_led #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] vinp,
  input  logic       enchx,
  output logic [6:0] leds
);

  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] LEDS_BLANK  = ACTIVE_LOW ? ~GLYPH_BLANK : GLYPH_BLANK;

  logic [6:0] glyph;
  logic [6:0] leds_nxt;

  // Active-high gfedcba; decimal mode folds 10..15 into the dash.
  always_comb begin
    glyph = GLYPH_DASH;
    if (enchx || (vinp < 4'd10)) begin
      case (vinp)
        4'h0: glyph = 7'h3F;
        4'h1: glyph = 7'h06;
        4'h2: glyph = 7'h5B;
        4'h3: glyph = 7'h4F;
        4'h4: glyph = 7'h66;
        4'h5: glyph = 7'h6D;
        4'h6: glyph = 7'h7D;
        4'h7: glyph = 7'h07;
        4'h8: glyph = 7'h7F;
        4'h9: glyph = 7'h6F;
        4'hA: glyph = 7'h77;
        4'hB: glyph = 7'h7C;
        4'hC: glyph = 7'h39;
        4'hD: glyph = 7'h5E;
        4'hE: glyph = 7'h79;
        4'hF: glyph = 7'h71;
        default: glyph = GLYPH_DASH;
      endcase
    end
  end

  always_comb begin
    leds_nxt = ACTIVE_LOW ? ~glyph : glyph;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= LEDS_BLANK;
    end else begin
      leds <= leds_nxt;
    end
  end

endmodule

// File: tb/tb_enc7_led.sv
// Bench for enc7_led: both polarities side by side, directed steps plus random
// traffic checked against a glyph-table model.
module tb_enc7_led;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] vinp = 4'd0;
  logic       enchx = 1'b1;
  logic [6:0] leds_al;
  logic [6:0] leds_ah;

  int checks = 0;
  int errors = 0;

  logic [6:0] hexg [16];
  logic [3:0] last_v;
  logic       last_e;

  enc7_led #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .vinp(vinp), .enchx(enchx), .leds(leds_al)
  );

  enc7_led #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst_n(rst_n), .vinp(vinp), .enchx(enchx), .leds(leds_ah)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_hi(input logic [3:0] v, input logic e);
    if (e || int'(v) <= 9) return hexg[v];
    return 7'h40;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [3:0] v, input logic e);
    chk({tag, "_al"}, leds_al, ~model_hi(v, e));
    chk({tag, "_ah"}, leds_ah, model_hi(v, e));
  endtask

  // Apply a pair at the falling edge, then check just after the next rising edge.
  task automatic step(input string tag, input logic [3:0] v, input logic e);
    @(negedge clk);
    vinp  = v;
    enchx = e;
    @(posedge clk);
    #1;
    chk_both(tag, v, e);
    last_v = v;
    last_e = e;
  endtask

  initial begin
    logic [6:0] sweep_al [16];
    sweep_al = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    hexg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Run once out of reset, then assert reset asynchronously mid-cycle.
    #2;
    rst_n = 1'b1;
    step("pre_reset", 4'd8, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_al", leds_al, 7'h7F);
    chk("rst_async_ah", leds_ah, 7'h00);
    vinp  = 4'd5;
    enchx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_al", leds_al, 7'h7F);
    chk("rst_hold_ah", leds_ah, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_rel_wait_al", leds_al, 7'h7F);
    @(posedge clk);
    #1;
    chk("rst_first_al", leds_al, 7'h12);
    chk("rst_first_ah", leds_ah, 7'h6D);

    // Hex sweep against the literal table as well as the model.
    for (int i = 0; i < 16; i++) begin
      step("hex_sweep", 4'(i), 1'b1);
      chk("hex_sweep_lit", leds_al, sweep_al[i]);
    end

    // Decimal mode boundaries.
    step("dec9", 4'd9, 1'b0);
    chk("dec9_lit", leds_al, 7'h10);
    step("dec10", 4'd10, 1'b0);
    chk("dec10_lit", leds_al, 7'h3F);
    step("dec15", 4'd15, 1'b0);
    chk("dec15_lit", leds_al, 7'h3F);

    // Mode toggle on a held value.
    step("tog1", 4'hC, 1'b1);
    chk("tog1_lit", leds_al, 7'h46);
    step("tog0", 4'hC, 1'b0);
    chk("tog0_lit", leds_al, 7'h3F);
    step("tog1b", 4'hC, 1'b1);
    chk("tog1b_lit", leds_al, 7'h46);

    // Active-high polarity literals.
    step("pol8", 4'd8, 1'b1);
    chk("pol8_lit", leds_ah, 7'h7F);
    step("pol1", 4'd1, 1'b1);
    chk("pol1_lit", leds_ah, 7'h06);

    // Mid-cycle changes must not reach leds before the edge.
    for (int k = 0; k < 4; k++) begin
      logic [3:0] v;
      logic       e;
      @(negedge clk);
      repeat (3) begin
        v = 4'($urandom_range(15));
        e = 1'($urandom_range(1));
        vinp  = v;
        enchx = e;
        #1;
        chk_both("glitch_hold", last_v, last_e);
      end
      @(posedge clk);
      #1;
      chk_both("glitch_edge", v, e);
      last_v = v;
      last_e = e;
    end

    // Reset in the middle of traffic overrides the pending update.
    @(negedge clk);
    vinp  = 4'd2;
    enchx = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_al", leds_al, 7'h7F);
    chk("rst_mid_ah", leds_ah, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      step("rand", 4'($urandom_range(15)), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
